usb_rx_phy: RTL and testbench
=============================

// Module: usb_rx_phy
// PURPOSE
//  Full-speed (12 Mb/s) USB receive front end between the raw D+/D- pins and the packet receiver.
//  Synchronises the lines and recovers bit timing from 4x oversampling at 48 MHz.
//  Performs NRZI decode, bit unstuffing, SYNC detection, EOP detection and bus-reset detection.
//  Emits a strobed stream of decoded data bits, LSB first, framed by start and end pulses.
// PARAMETERS
//  SYNC_STAGES      2    flops per line in the input synchroniser (>=2)
//  SAMPLES_PER_BIT  4    clock48 cycles per bit; the phase counter width is its log2
//  SAMPLE_PHASE     2    phase-counter value at which the line is sampled (mid-bit)
//  RESET_CYCLES     120  continuous SE0 cycles (2.5 us) before bus_reset asserts
//  STUFF_LIMIT      6    consecutive decoded 1s after which a stuffed 0 is expected
// PORTS
//  clock48       in   1  48 MHz clock
//  reset         in   1  synchronous, active-high
//  usb_d_p       in   1  raw D+, asynchronous
//  usb_d_n       in   1  raw D-, asynchronous
//  rx_active     out  1  high from packet_start to packet_end or abort
//  packet_start  out  1  1-cycle pulse: valid SYNC received
//  bit_valid     out  1  1-cycle pulse: bit_data holds the next decoded payload bit
//  bit_data      out  1  decoded, unstuffed bit; qualified by bit_valid
//  packet_end    out  1  1-cycle pulse: EOP (SE0 then J) completed a good packet
//  rx_error      out  1  1-cycle pulse: stuff error, SE1, bad SYNC or EOP mid-bit
//  bus_reset     out  1  level; high while SE0 has persisted >= RESET_CYCLES
// BEHAVIOUR
//  Interface: one clock (clock48); reset is synchronous and active-high.
//  Reset: all outputs 0, state IDLE, phase 0, prev_line = J, ones count 0, SE0 counter 0.
//  Reset mid-packet aborts the packet silently: no packet_end and no rx_error.
//  Line state (after sync): J={1,0}, K={0,1}, SE0={0,0}, SE1={1,1}.
//  DPLL: phase resets to 0 on any change of synchronised line state; otherwise it increments and wraps.
//  A sample occurs in the cycle where phase==SAMPLE_PHASE.
//  NRZI: decoded bit = 1 if sampled J/K equals prev_line, else 0; prev_line updates every sample.
//  Unstuffing: after STUFF_LIMIT consecutive decoded 1s, the next sample is dropped.
//  If that dropped sample decodes to 1, raise rx_error and go to IGNORE.
//  Outputs are registered; every pulse appears the cycle after its sample.
//  Latency: pin edge -> bit_valid = SYNC_STAGES + SAMPLE_PHASE + 2 cycles.
//  State IDLE:
//   - K sampled -> SYNC; prev_line=J, sync shift register cleared, counter=1 (this K decodes to 0).
//  State SYNC:
//   - Shift decoded bits until 8 are collected.
//   - Value 8'h80 (KJKJKJKK, LSB first) -> packet_start, rx_active=1, go to DATA.
//   - Any other value -> rx_error, go to IGNORE.
//   - Unstuffing is not applied inside SYNC.
//  State DATA:
//   - Each unstuffed bit -> bit_valid and bit_data.
//   - SE0 sample -> go to EOP; ones count cleared.
//   - SE1 sample -> rx_error, rx_active=0, go to IGNORE.
//  State EOP:
//   - Further SE0 samples are tolerated, up to 2 more.
//   - J sample -> packet_end, rx_active=0, go to IDLE.
//   - K sample, SE1, or a 4th SE0 sample -> rx_error, rx_active=0, go to IGNORE.
//  State IGNORE:
//   - No pulses; wait for SE0 followed by J, then go to IDLE.
//   - Also exit to IDLE after 8 consecutive J samples.
//  bus_reset:
//   - A 16-bit saturating counter counts cycles of synchronised SE0 and clears on non-SE0.
//   - bus_reset = counter >= RESET_CYCLES.
//   - While bus_reset is high, state is forced to IDLE; rx_active=0; no packet_end, no rx_error.
//  Simultaneous events: bus_reset beats every other condition; rx_error beats packet_end.
//  packet_start and bit_valid never coincide.
//  Payload bit count is not checked here; bit_valid never asserts outside DATA.
// STRUCTURE
//  Package usb_pkg:
//   - LINE_J/LINE_K/LINE_SE0/LINE_SE1 2-bit constants.
//   - rx_state_t enum {IDLE, SYNC, DATA, EOP, IGNORE}.
//   - SYNC_PATTERN = 8'h80.
//  Sub-module usb_line_sync: SYNC_STAGES-deep two-bit synchroniser with reset to J.
//  The DPLL, NRZI, unstuffing and FSM stay in this module.
// TESTING
//  1. Reset, J idle, then SYNC + byte 8'hA5 + SE0 x2 bits + J:
//     -> packet_start once; 8 bit_valid with bits 1,0,1,0,0,1,0,1; packet_end once; rx_error 0.
//  2. Byte 8'hFF after SYNC (stuffed 0 after 6 ones):
//     -> exactly 8 bit_valid all 1; stuffed bit dropped; no error.
//  3. Seven consecutive decoded 1s (missing stuff bit) -> rx_error 1 pulse, no further bit_valid, packet_end 0.
//  4. Bit edges jittered by +/-1 clock48 across a 4-byte packet:
//     -> all 32 bits decoded correctly; phase realigns on every edge.
//  5. SE0 held 200 cycles mid-packet:
//     -> bus_reset high from the 120th SE0 cycle, rx_active 0, no packet_end.
//     -> J then a new SYNC -> packet_start.
//  6. Corrupt SYNC KJKJKJKJ -> rx_error, no packet_start.
//     -> After SE0+J, a good SYNC gives packet_start.
//     -> reset asserted mid-DATA clears rx_active next cycle with no pulses.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared line-state encodings, receiver states and SYNC pattern for the
// full-speed USB receive front end.
package usb_pkg;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    IGNORE
  } rx_state_t;

  // NRZI: no transition between samples carries a 1.
  function automatic logic nrzi_decode(input logic [1:0] line, input logic [1:0] prev);
    return (line == prev);
  endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Multi-flop synchroniser for the asynchronous D+/D- pins; resets to the
// idle J state so no spurious edge is seen leaving reset.
module usb_line_sync
  import usb_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       d_p_i,
  input  logic       d_n_i,
  output logic [1:0] line_o
);

  logic [STAGES-1:0] dp_q;
  logic [STAGES-1:0] dn_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dp_q <= {STAGES{LINE_J[1]}};
      dn_q <= {STAGES{LINE_J[0]}};
    end else begin
      dp_q <= {dp_q[STAGES-2:0], d_p_i};
      dn_q <= {dn_q[STAGES-2:0], d_n_i};
    end
  end

  assign line_o = {dp_q[STAGES-1], dn_q[STAGES-1]};

endmodule

// File: rtl/usb_rx_phy.sv
// Full-speed USB receive front end: 4x-oversampling DPLL, NRZI decode,
// bit unstuffing, SYNC/EOP framing and bus-reset detection.
module usb_rx_phy
  import usb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned SAMPLES_PER_BIT = 4,
  parameter int unsigned SAMPLE_PHASE    = 2,
  parameter int unsigned RESET_CYCLES    = 120,
  parameter int unsigned STUFF_LIMIT     = 6
) (
  input  logic clock48,
  input  logic reset,
  input  logic usb_d_p,
  input  logic usb_d_n,
  output logic rx_active,
  output logic packet_start,
  output logic bit_valid,
  output logic bit_data,
  output logic packet_end,
  output logic rx_error,
  output logic bus_reset
);

  localparam int unsigned    PW         = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [PW-1:0]  PH_SAMPLE  = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0]  PH_LAST    = PW'(SAMPLES_PER_BIT - 1);
  localparam int unsigned    OW         = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0]  ONES_MAX   = OW'(STUFF_LIMIT);
  localparam logic [15:0]    RST_THRESH = 16'(RESET_CYCLES);

  logic [1:0]    line_s;
  logic [1:0]    line_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   se0_cnt_q, se0_cnt_d;
  logic          bus_reset_q, bus_reset_d;
  rx_state_t     state_q, state_d;
  logic [1:0]    prev_q, prev_d;
  logic [7:0]    sreg_q, sreg_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [1:0]    eop_cnt_q, eop_cnt_d;
  logic [2:0]    ign_j_q, ign_j_d;
  logic          ign_se0_q, ign_se0_d;
  logic          active_q, active_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic          data_q, data_d;
  logic          end_q, end_d;
  logic          err_q, err_d;

  logic          sample_s;
  logic          dec_s;
  logic          line_jk_s;
  logic [7:0]    sync_shift_s;

  usb_line_sync #(
    .STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_i  (clock48),
    .reset_i(reset),
    .d_p_i  (usb_d_p),
    .d_n_i  (usb_d_n),
    .line_o (line_s)
  );

  // line_q/phase_q describe the same stable interval, so sampling uses line_q.
  assign sample_s     = (phase_q == PH_SAMPLE);
  assign dec_s        = nrzi_decode(line_q, prev_q);
  assign line_jk_s    = (line_q == LINE_J) || (line_q == LINE_K);
  assign sync_shift_s = {dec_s, sreg_q[7:1]};

  // DPLL phase tracking and bus-reset SE0 timer.
  always_comb begin
    phase_d   = phase_q;
    se0_cnt_d = se0_cnt_q;
    if (line_s != line_q) begin
      phase_d = {PW{1'b0}};
    end else if (phase_q == PH_LAST) begin
      phase_d = {PW{1'b0}};
    end else begin
      phase_d = phase_q + PW'(1'b1);
    end
    if (line_s != LINE_SE0) begin
      se0_cnt_d = 16'd0;
    end else if (se0_cnt_q != 16'hFFFF) begin
      se0_cnt_d = se0_cnt_q + 16'd1;
    end else begin
      se0_cnt_d = se0_cnt_q;
    end
    bus_reset_d = (se0_cnt_d >= RST_THRESH);
  end

  // Receiver FSM; IGNORE trackers are held clear outside IGNORE.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    sreg_d    = sreg_q;
    bcnt_d    = bcnt_q;
    ones_d    = ones_q;
    eop_cnt_d = eop_cnt_q;
    ign_j_d   = (state_q == IGNORE) ? ign_j_q : 3'd0;
    ign_se0_d = (state_q == IGNORE) ? ign_se0_q : 1'b0;
    active_d  = active_q;
    start_d   = 1'b0;
    valid_d   = 1'b0;
    data_d    = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;

    if (bus_reset_d) begin
      state_d  = IDLE;
      active_d = 1'b0;
    end else if (sample_s) begin
      case (state_q)
        IDLE: begin
          if (line_q == LINE_K) begin
            // First SYNC bit decodes to 0 against an implied J.
            state_d = SYNC;
            prev_d  = LINE_K;
            sreg_d  = 8'h00;
            bcnt_d  = 3'd1;
          end else begin
            state_d = IDLE;
          end
        end
        SYNC: begin
          if (!line_jk_s) begin
            err_d   = 1'b1;
            state_d = IGNORE;
          end else if (bcnt_q == 3'd7) begin
            prev_d = line_q;
            sreg_d = sync_shift_s;
            // Stuffing run starts fresh with the first payload bit.
            ones_d = {OW{1'b0}};
            if (sync_shift_s == SYNC_PATTERN) begin
              start_d  = 1'b1;
              active_d = 1'b1;
              state_d  = DATA;
            end else begin
              err_d   = 1'b1;
              state_d = IGNORE;
            end
          end else begin
            prev_d = line_q;
            sreg_d = sync_shift_s;
            bcnt_d = bcnt_q + 3'd1;
          end
        end
        DATA: begin
          case (line_q)
            LINE_SE0: begin
              state_d   = EOP;
              ones_d    = {OW{1'b0}};
              eop_cnt_d = 2'd1;
            end
            LINE_SE1: begin
              err_d    = 1'b1;
              active_d = 1'b0;
              state_d  = IGNORE;
            end
            default: begin
              prev_d = line_q;
              if (ones_q == ONES_MAX) begin
                if (dec_s) begin
                  err_d    = 1'b1;
                  active_d = 1'b0;
                  state_d  = IGNORE;
                end else begin
                  ones_d = {OW{1'b0}};
                end
              end else begin
                valid_d = 1'b1;
                data_d  = dec_s;
                ones_d  = dec_s ? (ones_q + OW'(1'b1)) : {OW{1'b0}};
              end
            end
          endcase
        end
        EOP: begin
          if (line_q == LINE_J) begin
            end_d    = 1'b1;
            active_d = 1'b0;
            state_d  = IDLE;
          end else if ((line_q == LINE_SE0) && (eop_cnt_q != 2'd3)) begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end else begin
            err_d    = 1'b1;
            active_d = 1'b0;
            state_d  = IGNORE;
          end
        end
        IGNORE: begin
          if (line_q == LINE_SE0) begin
            ign_se0_d = 1'b1;
            ign_j_d   = 3'd0;
          end else if (line_q == LINE_J) begin
            if (ign_se0_q || (ign_j_q == 3'd7)) begin
              state_d = IDLE;
            end else begin
              ign_j_d = ign_j_q + 3'd1;
            end
          end else begin
            ign_se0_d = 1'b0;
            ign_j_d   = 3'd0;
          end
        end
        default: begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clock48) begin
    if (reset) begin
      line_q      <= LINE_J;
      phase_q     <= {PW{1'b0}};
      se0_cnt_q   <= 16'd0;
      bus_reset_q <= 1'b0;
      state_q     <= IDLE;
      prev_q      <= LINE_J;
      sreg_q      <= 8'h00;
      bcnt_q      <= 3'd0;
      ones_q      <= {OW{1'b0}};
      eop_cnt_q   <= 2'd0;
      ign_j_q     <= 3'd0;
      ign_se0_q   <= 1'b0;
      active_q    <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      line_q      <= line_s;
      phase_q     <= phase_d;
      se0_cnt_q   <= se0_cnt_d;
      bus_reset_q <= bus_reset_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      sreg_q      <= sreg_d;
      bcnt_q      <= bcnt_d;
      ones_q      <= ones_d;
      eop_cnt_q   <= eop_cnt_d;
      ign_j_q     <= ign_j_d;
      ign_se0_q   <= ign_se0_d;
      active_q    <= active_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      end_q       <= end_d;
      err_q       <= err_d;
    end
  end

  assign rx_active    = active_q;
  assign packet_start = start_q;
  assign bit_valid    = valid_q;
  assign bit_data     = data_q;
  assign packet_end   = end_q;
  assign rx_error     = err_q;
  assign bus_reset    = bus_reset_q;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Scoreboard bench for usb_rx_phy: line-level NRZI/stuffing encoder pushes
// expected framing/bit events, observed output pulses pop and compare them.
module tb_usb_rx_phy;
  import usb_pkg::*;

  localparam int EV_START = 0;
  localparam int EV_B0    = 1;
  localparam int EV_B1    = 2;
  localparam int EV_END   = 3;
  localparam int EV_ERR   = 4;

  logic clock48 = 1'b0;
  logic reset   = 1'b1;
  logic usb_d_p = 1'b1;
  logic usb_d_n = 1'b0;
  logic rx_active, packet_start, bit_valid, bit_data, packet_end, rx_error, bus_reset;

  int         checks_cnt = 0;
  int         errors_cnt = 0;
  int         exp_q[$];
  logic [1:0] tx_ls  = 2'b10;
  int         ones   = 0;
  int         jit_cur = 0;
  bit         jit_en = 1'b0;

  usb_rx_phy dut (
    .clock48     (clock48),
    .reset       (reset),
    .usb_d_p     (usb_d_p),
    .usb_d_n     (usb_d_n),
    .rx_active   (rx_active),
    .packet_start(packet_start),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .packet_end  (packet_end),
    .rx_error    (rx_error),
    .bus_reset   (bus_reset)
  );

  always #10 clock48 = ~clock48;

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got != exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic take(input int code);
    if (exp_q.size() == 0) check("evt_unexpected", code, -1);
    else check("evt", code, exp_q.pop_front());
  endtask

  // One clock: outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clock48);
    #2;
    if (packet_start) check("start_bv_overlap", int'(bit_valid), 0);
    if (packet_start) take(EV_START);
    if (bit_valid)    take(bit_data ? EV_B1 : EV_B0);
    if (packet_end)   take(EV_END);
    if (rx_error)     take(EV_ERR);
  endtask

  task automatic drive(input logic [1:0] ls, input int n);
    {usb_d_p, usb_d_n} = ls;
    repeat (n) tick();
  endtask

  // Edge offsets in {0,+1}: each edge moves by at most one clock.
  task automatic send_ls(input logic [1:0] ls);
    int d;
    int jn;
    d = 4;
    if (jit_en) begin
      jn      = int'($urandom_range(1, 0));
      d       = 4 + jn - jit_cur;
      jit_cur = jn;
    end
    drive(ls, d);
  endtask

  task automatic send_raw_bit(input logic b);
    if (!b) tx_ls = (tx_ls == LINE_J) ? LINE_K : LINE_J;
    send_ls(tx_ls);
  endtask

  task automatic send_sync(input bit good);
    exp_q.push_back(good ? EV_START : EV_ERR);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) tx_ls = good ? LINE_K : LINE_J;
      else tx_ls = ((i % 2) == 0) ? LINE_K : LINE_J;
      send_ls(tx_ls);
    end
    ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i] ? EV_B1 : EV_B0);
      send_raw_bit(b[i]);
      ones = b[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_raw_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop(input bit good);
    if (good) exp_q.push_back(EV_END);
    send_ls(LINE_SE0);
    send_ls(LINE_SE0);
    tx_ls = LINE_J;
    send_ls(LINE_J);
    drive(LINE_J, 12);
  endtask

  task automatic finish_test(input string tag);
    jit_en  = 1'b0;
    jit_cur = 0;
    tx_ls   = LINE_J;
    drive(LINE_J, 24);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    drive(LINE_J, 4);
    check("rst_active", int'(rx_active), 0);
    check("rst_start",  int'(packet_start), 0);
    check("rst_valid",  int'(bit_valid), 0);
    check("rst_data",   int'(bit_data), 0);
    check("rst_end",    int'(packet_end), 0);
    check("rst_error",  int'(rx_error), 0);
    check("rst_busrst", int'(bus_reset), 0);
    reset = 1'b0;
    drive(LINE_J, 16);

    // 1: basic packet
    send_sync(1'b1);
    send_byte(8'hA5);
    check("t1_active", int'(rx_active), 1);
    send_eop(1'b1);
    check("t1_active_after", int'(rx_active), 0);
    finish_test("t1_drain");

    // 2: all ones with stuffed zero
    send_sync(1'b1);
    send_byte(8'hFF);
    send_eop(1'b1);
    finish_test("t2_drain");

    // 3: missing stuff bit
    send_sync(1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(EV_B1);
    exp_q.push_back(EV_ERR);
    for (int i = 0; i < 7; i++) send_raw_bit(1'b1);
    send_eop(1'b0);
    check("t3_active", int'(rx_active), 0);
    finish_test("t3_drain");

    // 4: jittered edges across a four-byte packet
    jit_en  = 1'b1;
    jit_cur = 0;
    send_sync(1'b1);
    send_byte(8'hC3);
    send_byte(8'h5A);
    send_byte(8'hFF);
    send_byte(8'h01);
    send_eop(1'b1);
    finish_test("t4_drain");

    // 5: long SE0 mid-packet, EOP overrun then bus reset
    send_sync(1'b1);
    send_byte(8'h12);
    exp_q.push_back(EV_ERR);
    drive(LINE_SE0, 100);
    check("t5_busrst_early", int'(bus_reset), 0);
    drive(LINE_SE0, 100);
    check("t5_busrst", int'(bus_reset), 1);
    check("t5_active", int'(rx_active), 0);
    tx_ls = LINE_J;
    drive(LINE_J, 8);
    check("t5_busrst_clear", int'(bus_reset), 0);
    send_sync(1'b1);
    send_byte(8'h34);
    send_eop(1'b1);
    finish_test("t5_drain");

    // 6: corrupt SYNC, recovery, then reset mid-DATA
    send_sync(1'b0);
    send_eop(1'b0);
    check("t6_bad_sync_drain", exp_q.size(), 0);
    tx_ls = LINE_J;
    drive(LINE_J, 8);
    send_sync(1'b1);
    send_byte(8'hA5);
    drive(tx_ls, 3);
    check("t6_active_pre", int'(rx_active), 1);
    reset = 1'b1;
    tx_ls = LINE_J;
    drive(LINE_J, 1);
    check("t6_rst_active", int'(rx_active), 0);
    check("t6_rst_end", int'(packet_end), 0);
    check("t6_rst_error", int'(rx_error), 0);
    drive(LINE_J, 2);
    reset = 1'b0;
    finish_test("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
